// File: rtl/conv_window_ctrl.sv
// rtl/conv_window_ctrl.sv - 3x3 window read sequencer for the P x P image buffer RAM
// Optional stall input enabled by defining WINCTRL_STALL_EN.
module conv_window_ctrl #(
    parameter int P  = 28,
    parameter int M  = 10,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ram_full,
`ifdef WINCTRL_STALL_EN
    input  logic          stall,
`endif
    output logic          ram_rd,
    output logic [M-1:0]  ram_adr,
    output logic          tap_valid,
    output logic [3:0]    tap_idx,
    output logic          win_valid,
    output logic [RW-1:0] out_row,
    output logic [RW-1:0] out_col,
    output logic          busy,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, WAIT, READ, DONE} state_t;

    localparam logic [RW-1:0] LAST     = RW'(P - 3);
    // Address steps between consecutive taps, relative to the tap just issued
    localparam logic [M-1:0]  ROW_STEP = M'(P - 2);
    localparam logic [M-1:0]  WIN_BACK = M'(2 * P + 1);
    localparam logic [M-1:0]  ROW_BACK = M'(2 * P - 1);

    state_t        state;
    logic          loaded;
    logic          win_sent;
    logic [RW-1:0] r;
    logic [RW-1:0] c;
    logic          hold;
    logic          go;
    logic          enter_read;
    logic          tap8;
    logic          last_tap;

`ifdef WINCTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign go         = loaded | ram_full;
    assign enter_read = go && ((state == IDLE && start) || state == WAIT);
    assign tap8       = (tap_idx == 4'd8);
    assign last_tap   = tap8 && (r == LAST) && (c == LAST);

    // r/c/tap_idx/ram_adr always describe the tap most recently issued
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            loaded    <= 1'b0;
            win_sent  <= 1'b0;
            r         <= '0;
            c         <= '0;
            ram_rd    <= 1'b0;
            ram_adr   <= '0;
            tap_valid <= 1'b0;
            tap_idx   <= '0;
            win_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            win_valid <= 1'b0;
            done      <= 1'b0;
            if (ram_full)
                loaded <= 1'b1;
            else if (enter_read)
                loaded <= 1'b0;

            if (enter_read) begin
                state     <= READ;
                busy      <= 1'b1;
                ram_rd    <= 1'b1;
                tap_valid <= 1'b1;
                ram_adr   <= '0;
                tap_idx   <= '0;
                r         <= '0;
                c         <= '0;
                win_sent  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= WAIT;
                            busy  <= 1'b1;
                        end
                    end
                    READ: begin
                        // win_sent keeps a stalled tap 8 from pulsing win_valid twice
                        if (tap8 && !win_sent) begin
                            win_valid <= 1'b1;
                            out_row   <= r;
                            out_col   <= c;
                        end
                        if (last_tap) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            ram_rd    <= 1'b0;
                            tap_valid <= 1'b0;
                        end else if (hold) begin
                            ram_rd    <= 1'b0;
                            tap_valid <= 1'b0;
                            if (tap8)
                                win_sent <= 1'b1;
                        end else begin
                            ram_rd    <= 1'b1;
                            tap_valid <= 1'b1;
                            win_sent  <= 1'b0;
                            if (tap8) begin
                                tap_idx <= '0;
                                if (c == LAST) begin
                                    c       <= '0;
                                    r       <= r + 1'b1;
                                    ram_adr <= ram_adr - ROW_BACK;
                                end else begin
                                    c       <= c + 1'b1;
                                    ram_adr <= ram_adr - WIN_BACK;
                                end
                            end else begin
                                tap_idx <= tap_idx + 4'd1;
                                ram_adr <= ram_adr + ((tap_idx == 4'd2 || tap_idx == 4'd5) ? ROW_STEP : M'(1));
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb/tb_conv_window_ctrl.sv - scoreboard bench for conv_window_ctrl (P=5)
module tb_conv_window_ctrl;
    localparam int P  = 5;
    localparam int M  = 5;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          ram_full = 1'b0;
`ifdef WINCTRL_STALL_EN
    logic          stall = 1'b0;
`endif
    logic          ram_rd;
    logic [M-1:0]  ram_adr;
    logic          tap_valid;
    logic [3:0]    tap_idx;
    logic          win_valid;
    logic [RW-1:0] out_row;
    logic [RW-1:0] out_col;
    logic          busy;
    logic          done;

    conv_window_ctrl #(.P(P), .M(M), .RW(RW)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ram_full(ram_full),
`ifdef WINCTRL_STALL_EN
        .stall(stall),
`endif
        .ram_rd(ram_rd),
        .ram_adr(ram_adr),
        .tap_valid(tap_valid),
        .tap_idx(tap_idx),
        .win_valid(win_valid),
        .out_row(out_row),
        .out_col(out_col),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int q_adr[$];
    int q_idx[$];
    int q_row[$];
    int q_col[$];
    int first_tap_cyc = -1;
    int ld_model = 0;
    bit prev_tap8 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: every window in raster order, taps row-major inside the window
    task automatic push_frame();
        for (int r = 0; r < P - 2; r++)
            for (int c = 0; c < P - 2; c++) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        q_adr.push_back((r + i) * P + c + j);
                        q_idx.push_back(3 * i + j);
                    end
                q_row.push_back(r);
                q_col.push_back(c);
            end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ram_rd"}, ram_rd, 0);
        chk({tag, "_ram_adr"}, ram_adr, 0);
        chk({tag, "_tap_valid"}, tap_valid, 0);
        chk({tag, "_tap_idx"}, tap_idx, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_out_row"}, out_row, 0);
        chk({tag, "_out_col"}, out_col, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a tap or a window
    always @(negedge clk) begin
        if (rst) begin
            prev_tap8 = 1'b0;
        end else begin
            if (tap_valid || ram_rd) begin
                chk("rd_eq_tap_valid", ram_rd, tap_valid);
                if (q_adr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tap: got adr %0d idx %0d, expected no tap", ram_adr, tap_idx);
                end else begin
                    chk("tap_adr", ram_adr, q_adr.pop_front());
                    chk("tap_idx", tap_idx, q_idx.pop_front());
                end
                if (tap_valid && ram_adr == 0 && tap_idx == 0)
                    first_tap_cyc = cyc;
            end
            if (win_valid || prev_tap8)
                chk("win_after_tap8", win_valid, prev_tap8);
            if (win_valid) begin
                if (q_row.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_win: got (%0d,%0d), expected no window", out_row, out_col);
                end else begin
                    chk("win_row", out_row, q_row.pop_front());
                    chk("win_col", out_col, q_col.pop_front());
                end
            end
            if (done) begin
                chk("done_with_win", win_valid, 1);
                chk("done_no_rd", ram_rd, 0);
                chk("done_busy", busy, 1);
            end
            prev_tap8 = tap_valid && (tap_idx == 8);
        end
    end

    task automatic wait_done(input bit noise, input bit stall_noise, output bit seen, output int t_done);
        seen = 1'b0;
        t_done = 0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                t_done = cyc;
                start = 1'b0;
`ifdef WINCTRL_STALL_EN
                stall = 1'b0;
`endif
            end else begin
                if (noise)
                    start = ($urandom_range(0, 3) == 0);
`ifdef WINCTRL_STALL_EN
                if (stall_noise)
                    stall = ($urandom_range(0, 2) == 0);
`endif
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 3000 cycles, expected done");
        end
    endtask

    task automatic run_frame(input bit pre_full, input int gap, input bit full_at_entry,
                             input bit noise, input bit stall_noise);
        int  n;
        int  exp_first;
        int  t_done;
        bit  seen;
        push_frame();
        if (pre_full) begin
            ram_full = 1'b1;
            tick();
            ram_full = 1'b0;
            ld_model = 1;
        end
        repeat ($urandom_range(0, 3)) tick();
        start = 1'b1;
        if (ld_model == 1 && full_at_entry)
            ram_full = 1'b1;
        tick();
        n = cyc;
        start = 1'b0;
        ram_full = 1'b0;
        if (ld_model == 1) begin
            exp_first = n;
            ld_model = full_at_entry ? 1 : 0;
        end else begin
            @(negedge clk);
            chk("wait_busy", busy, 1);
            chk("wait_no_rd", ram_rd, 0);
            repeat (gap) tick();
            ram_full = 1'b1;
            tick();
            n = cyc;
            ram_full = 1'b0;
            exp_first = n;
        end
        wait_done(noise, stall_noise, seen, t_done);
        if (seen) begin
            chk("first_tap_cycle", first_tap_cyc, exp_first);
            if (!stall_noise)
                chk("frame_length", t_done - first_tap_cyc, 9 * (P - 2) * (P - 2));
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
        chk("tap_queue_empty", q_adr.size(), 0);
        chk("win_queue_empty", q_row.size(), 0);
        q_adr.delete(); q_idx.delete(); q_row.delete(); q_col.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (3) tick();
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // First frame with loaded set beforehand, second through WAIT after 20 idle cycles
        run_frame(1'b1, 0, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 20, 1'b0, 1'b0, 1'b0);

        // ram_full at READ entry keeps loaded, so the next start needs no ram_full
        run_frame(1'b1, 0, 1'b1, 1'b1, 1'b0);
        run_frame(1'b0, 0, 1'b0, 1'b1, 1'b0);

        // Abort during tap 4 of window (1,1); ram_full mid-frame must not survive reset
        push_frame();
        ram_full = 1'b1;
        tick();
        ram_full = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ram_full = 1'b1;
        tick();
        ram_full = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (tap_valid && tap_idx == 4 && ram_adr == 12)
                found = 1'b1;
        end
        chk("abort_point_found", found, 1);
        rst = 1'b1;
        tick();
        q_adr.delete(); q_idx.delete(); q_row.delete(); q_col.delete();
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        ld_model = 0;
        run_frame(1'b0, 5, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 3; k++)
            run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 10), 1'($urandom_range(0, 1)), 1'b1, 1'b0);

`ifdef WINCTRL_STALL_EN
        begin
            int  t_done;
            bit  seen;
            push_frame();
            ram_full = 1'b1;
            tick();
            ram_full = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
            found = 1'b0;
            for (int k = 0; k < 50 && !found; k++) begin
                @(negedge clk);
                if (tap_valid && tap_idx == 7 && ram_adr == 11)
                    found = 1'b1;
            end
            chk("stall_point_found", found, 1);
            stall = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                chk("stall_no_rd", ram_rd, 0);
            end
            stall = 1'b0;
            @(negedge clk);
            chk("resume_adr", ram_adr, 12);
            chk("resume_idx", tap_idx, 8);
            wait_done(1'b0, 1'b0, seen, t_done);
            @(negedge clk);
            chk("stall_tap_queue_empty", q_adr.size(), 0);
            chk("stall_win_queue_empty", q_row.size(), 0);
            q_adr.delete(); q_idx.delete(); q_row.delete(); q_col.delete();
            ld_model = 0;
        end
        run_frame(1'b1, 0, 1'b0, 1'b1, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
